// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, fetches over a req/ready handshake,
// latches the instruction and resolves the next PC from pcsrc/jump.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pcsrc,
  input  logic        jump,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [5:0]  funct,
  output logic [31:0] pc,
  output logic [31:0] pcplus4,
  output logic        instr_valid,
  output logic        fetch_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    FAULT = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   instr_q, instr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [31:0] pc4;
  logic [31:0] br_off;
  logic [31:0] br_tgt;
  logic [31:0] j_tgt;
  logic [31:0] next_pc;

  assign pc4    = pc_q + 32'd4;
  assign br_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
  assign br_tgt = pc4 + br_off;
  assign j_tgt  = {pc4[31:28], instr_q[25:0], 2'b00};

  // Jump beats branch, branch beats fall-through
  always_comb begin
    next_pc = pc4;
    priority case (1'b1)
      jump:    next_pc = j_tgt;
      pcsrc:   next_pc = br_tgt;
      default: next_pc = pc4;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: a completing transfer beats the timeout
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  state_d = FETCH;
      FETCH: begin
        if (imem_ready)           state_d = EXEC;
        else if (cnt_q == CNT_LAST) state_d = FAULT;
      end
      EXEC:  if (!stall) state_d = FETCH;
      FAULT: state_d = FAULT;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: PC, instruction register, wait counter
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      FETCH: begin
        if (imem_ready) begin
          instr_d = imem_rdata;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      EXEC:    if (!stall) pc_d = next_pc;
      default: cnt_d = '0;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q    <= RESET_PC;
      instr_q <= '0;
      cnt_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Handshake and status outputs decoded from state
  always_comb begin
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    fetch_err   = 1'b0;
    unique case (state_q)
      FETCH:   imem_req    = 1'b1;
      EXEC:    instr_valid = 1'b1;
      FAULT:   fetch_err   = 1'b1;
      default: ;
    endcase
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign pcplus4   = pc4;
  assign instr     = instr_q;
  assign op        = instr_q[31:26];
  assign funct     = instr_q[5:0];

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: three instances with different reset PCs,
// expected fetch addresses are queued and popped at each request.
module tb_instr_fetch;

  localparam logic [31:0] RPC0 = 32'h0000_0100;
  localparam logic [31:0] RPC1 = 32'h8000_0000;
  localparam logic [31:0] RPC2 = 32'hFFFF_FFFC;

  logic clk;
  logic [2:0] rst_n;
  logic [2:0] pcsrc;
  logic [2:0] jump;
  logic [2:0] stall;
  logic [2:0] imem_req;
  logic [2:0][31:0] imem_addr;
  logic [2:0][31:0] imem_rdata;
  logic [2:0] imem_ready;
  logic [2:0][31:0] instr;
  logic [2:0][5:0] op;
  logic [2:0][5:0] funct;
  logic [2:0][31:0] pc;
  logic [2:0][31:0] pcplus4;
  logic [2:0] instr_valid;
  logic [2:0] fetch_err;

  int checks = 0;
  int fails  = 0;
  logic [31:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam logic [31:0] RPC =
      (g == 0) ? RPC0 : (g == 1) ? RPC1 : RPC2;
    instr_fetch #(
      .RESET_PC(RPC),
      .TIMEOUT (16)
    ) u_dut (
      .clk        (clk),
      .reset      (rst_n[g]),
      .pcsrc      (pcsrc[g]),
      .jump       (jump[g]),
      .stall      (stall[g]),
      .imem_req   (imem_req[g]),
      .imem_addr  (imem_addr[g]),
      .imem_rdata (imem_rdata[g]),
      .imem_ready (imem_ready[g]),
      .instr      (instr[g]),
      .op         (op[g]),
      .funct      (funct[g]),
      .pc         (pc[g]),
      .pcplus4    (pcplus4[g]),
      .instr_valid(instr_valid[g]),
      .fetch_err  (fetch_err[g])
    );
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_addr(input int d);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("addr", imem_addr[d], e);
    end
  endtask

  task automatic wait_req(input int d, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req[d]) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) check("req_timeout", 32'd0, 32'd1);
  endtask

  // One instruction: serve the fetch, check EXEC, stall, queue next PC
  task automatic serve(input int d, input logic [31:0] word,
                       input logic pcs, input logic jmp,
                       input int nstall, input logic [31:0] nxt);
    bit ok;
    logic [31:0] cur;
    wait_req(d, ok);
    if (!ok) return;
    cur = imem_addr[d];
    pop_addr(d);
    imem_rdata[d] = word;
    imem_ready[d] = 1'b1;
    pcsrc[d] = pcs;
    jump[d]  = jmp;
    stall[d] = (nstall > 0);
    tick();
    imem_ready[d] = 1'b0;
    imem_rdata[d] = 32'hDEAD_BEEF;
    check("valid", {31'd0, instr_valid[d]}, 32'd1);
    check("instr", instr[d], word);
    check("op", {26'd0, op[d]}, {26'd0, word[31:26]});
    check("funct", {26'd0, funct[d]}, {26'd0, word[5:0]});
    check("pc", pc[d], cur);
    check("pcplus4", pcplus4[d], cur + 32'd4);
    check("req_exec", {31'd0, imem_req[d]}, 32'd0);
    for (int s = 0; s < nstall; s++) begin
      tick();
      check("stall_valid", {31'd0, instr_valid[d]}, 32'd1);
      check("stall_instr", instr[d], word);
      check("stall_pc", pc[d], cur);
      check("stall_req", {31'd0, imem_req[d]}, 32'd0);
      if (s == nstall - 1) stall[d] = 1'b0;
    end
    exp_q.push_back(nxt);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    logic [31:0] beq_neg;
    logic [31:0] jw;
    rst_n = '0;
    pcsrc = '0;
    jump = '0;
    stall = '0;
    imem_ready = '0;
    imem_rdata = '0;
    tick();

    // Reset state
    check("rst_pc", pc[0], RPC0);
    check("rst_instr", instr[0], 32'd0);
    check("rst_req", {31'd0, imem_req[0]}, 32'd0);
    check("rst_valid", {31'd0, instr_valid[0]}, 32'd0);
    check("rst_err", {31'd0, fetch_err[0]}, 32'd0);

    // Back-to-back fetches with ready tied high
    imem_ready[0] = 1'b1;
    imem_rdata[0] = 32'd0;
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    exp_q.push_back(32'h108);
    rst_n[0] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("v_pattern", {31'd0, instr_valid[0]}, {31'd0, k[0]});
      check("r_pattern", {31'd0, imem_req[0]}, {31'd0, ~k[0]});
      if (imem_req[0]) pop_addr(0);
    end
    imem_ready[0] = 1'b0;
    exp_q.push_back(32'h10C);

    // Branches: 0x10C -> 0x40, imm=-1 -> 0x40, imm=3 -> 0x50
    beq_neg = {6'd4, 10'd0, 16'hFFCC};
    serve(0, beq_neg, 1'b1, 1'b0, 0, 32'h40);
    serve(0, {6'd4, 10'd0, 16'hFFFF}, 1'b1, 1'b0, 0, 32'h40);
    serve(0, {6'd4, 10'd0, 16'h0003}, 1'b1, 1'b0, 0, 32'h50);
    // Branch bits present but pcsrc low: sequential
    serve(0, {6'd4, 10'd0, 16'h0100}, 1'b0, 1'b0, 3, 32'h54);

    // Ready on wait cycle 16 completes without fault
    wait_req(0, ok);
    pop_addr(0);
    repeat (15) tick();
    check("w15_req", {31'd0, imem_req[0]}, 32'd1);
    check("w15_err", {31'd0, fetch_err[0]}, 32'd0);
    imem_ready[0] = 1'b1;
    imem_rdata[0] = 32'h0000_0020;
    tick();
    imem_ready[0] = 1'b0;
    check("w16_valid", {31'd0, instr_valid[0]}, 32'd1);
    check("w16_err", {31'd0, fetch_err[0]}, 32'd0);
    exp_q.push_back(32'h58);

    // Ready never comes: fault after 16 waiting edges
    wait_req(0, ok);
    pop_addr(0);
    repeat (15) tick();
    check("t15_err", {31'd0, fetch_err[0]}, 32'd0);
    tick();
    check("t16_err", {31'd0, fetch_err[0]}, 32'd1);
    check("t16_req", {31'd0, imem_req[0]}, 32'd0);
    check("t16_valid", {31'd0, instr_valid[0]}, 32'd0);
    imem_ready[0] = 1'b1;
    repeat (3) tick();
    imem_ready[0] = 1'b0;
    check("sticky_err", {31'd0, fetch_err[0]}, 32'd1);

    // Reset clears the fault
    #2 rst_n[0] = 1'b0;
    #1;
    check("clr_err", {31'd0, fetch_err[0]}, 32'd0);
    check("clr_pc", pc[0], RPC0);
    rst_n[0] = 1'b1;
    exp_q.push_back(32'h100);
    serve(0, 32'd0, 1'b0, 1'b0, 0, 32'h104);

    // Async reset mid-FETCH with wait counter at 5
    wait_req(0, ok);
    pop_addr(0);
    repeat (5) tick();
    check("mid_req", {31'd0, imem_req[0]}, 32'd1);
    #3 rst_n[0] = 1'b0;
    #1;
    check("async_pc", pc[0], RPC0);
    check("async_req", {31'd0, imem_req[0]}, 32'd0);
    check("async_instr", instr[0], 32'd0);
    check("async_valid", {31'd0, instr_valid[0]}, 32'd0);
    check("async_err", {31'd0, fetch_err[0]}, 32'd0);
    #2 rst_n[0] = 1'b1;

    // Counter restarted: 15 idle waits must not fault
    exp_q.push_back(32'h100);
    wait_req(0, ok);
    pop_addr(0);
    repeat (15) tick();
    check("rcnt_err", {31'd0, fetch_err[0]}, 32'd0);
    check("rcnt_req", {31'd0, imem_req[0]}, 32'd1);
    rst_n[0] = 1'b0;

    // Jump beats branch at 0x8000_0000
    jw = {6'd2, 26'h000_0010};
    rst_n[1] = 1'b1;
    exp_q.push_back(32'h8000_0000);
    serve(1, jw, 1'b1, 1'b1, 0, 32'h8000_0040);
    serve(1, 32'd0, 1'b0, 1'b0, 0, 32'h8000_0044);
    wait_req(1, ok);
    pop_addr(1);
    rst_n[1] = 1'b0;

    // PC wraps from 0xFFFF_FFFC to 0
    rst_n[2] = 1'b1;
    exp_q.push_back(32'hFFFF_FFFC);
    serve(2, 32'd0, 1'b0, 1'b0, 0, 32'h0);
    wait_req(2, ok);
    pop_addr(2);
    rst_n[2] = 1'b0;

    check("sb_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
